// File: rtl/fifo2ram_dma.sv
`default_nettype none
// ============================================================================
// Module      : fifo2ram_dma
// Description : Drains the SPI write FIFO into block RAM as a burst, sharing
//               the single RAM write port with host writes (host has priority).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo2ram_dma #(
    parameter int WIDTH_DATA = 16,
    parameter int WIDTH_ADDR = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WIDTH_ADDR-1:0] base_addr,
    input  logic [WIDTH_ADDR:0]   length,
    output logic                  fifo_rreq,
    input  logic [WIDTH_DATA-1:0] fifo_rdata,
    input  logic                  fifo_rempty,
    input  logic                  host_wreq,
    input  logic [WIDTH_ADDR-1:0] host_waddr,
    input  logic [WIDTH_DATA-1:0] host_wdata,
    output logic                  ram_wreq,
    output logic [WIDTH_ADDR-1:0] ram_waddr,
    output logic [WIDTH_DATA-1:0] ram_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [WIDTH_ADDR:0]   xfer_cnt
);

    localparam logic [WIDTH_ADDR-1:0] c_ptr_one = {{(WIDTH_ADDR-1){1'b0}}, 1'b1};
    localparam logic [WIDTH_ADDR:0]   c_cnt_one = {{WIDTH_ADDR{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WIDTH_ADDR-1:0] r_ptr;
    logic [WIDTH_ADDR:0]   r_len;
    logic [WIDTH_ADDR:0]   r_cnt;
    logic                  r_aborted;
    logic                  r_ram_wreq;
    logic [WIDTH_ADDR-1:0] r_ram_waddr;
    logic [WIDTH_DATA-1:0] r_ram_wdata;
    logic                  w_start_ok;
    logic                  w_pop;
    logic                  w_last;

    assign w_start_ok = (r_state == IDLE) && start;
    // A host write or abort in the same cycle suppresses the pop; it is retried later.
    assign w_pop      = (r_state == XFER) && !fifo_rempty && !host_wreq && !abort
                        && (r_cnt != r_len);
    assign w_last     = w_pop && ((r_cnt + c_cnt_one) == r_len);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (length == '0) ? DONE : XFER;
                end
            end
            XFER: begin
                if (abort || w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_aborted <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_ptr     <= base_addr;
                r_len     <= length;
                r_cnt     <= '0;
                r_aborted <= 1'b0;
            end else if (w_pop) begin
                r_ptr <= r_ptr + c_ptr_one;
                r_cnt <= r_cnt + c_cnt_one;
            end
            if ((r_state == XFER) && abort) begin
                r_aborted <= 1'b1;
            end
        end
    end

    // Address/data hold their last value when neither source writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ram_wreq  <= 1'b0;
            r_ram_waddr <= '0;
            r_ram_wdata <= '0;
        end else if (host_wreq) begin
            r_ram_wreq  <= 1'b1;
            r_ram_waddr <= host_waddr;
            r_ram_wdata <= host_wdata;
        end else if (w_pop) begin
            r_ram_wreq  <= 1'b1;
            r_ram_waddr <= r_ptr;
            r_ram_wdata <= fifo_rdata;
        end else begin
            r_ram_wreq  <= 1'b0;
        end
    end

    assign fifo_rreq = w_pop;
    assign ram_wreq  = r_ram_wreq;
    assign ram_waddr = r_ram_waddr;
    assign ram_wdata = r_ram_wdata;
    assign busy      = (r_state == XFER);
    assign done      = (r_state == DONE);
    assign aborted   = r_aborted;
    assign xfer_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo2ram_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo2ram_dma
// Description : Directed self-checking bench for fifo2ram_dma.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo2ram_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  base_addr;
    logic [8:0]  length;
    logic        fifo_rreq;
    logic [15:0] fifo_rdata;
    logic        fifo_rempty;
    logic        host_wreq;
    logic [7:0]  host_waddr;
    logic [15:0] host_wdata;
    logic        ram_wreq;
    logic [7:0]  ram_waddr;
    logic [15:0] ram_wdata;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [8:0]  xfer_cnt;

    logic [15:0] q[$];
    logic [7:0]  t2a[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    int          total = 0;
    int          bad = 0;
    bit          pop;

    fifo2ram_dma #(.WIDTH_DATA(16), .WIDTH_ADDR(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length),
        .fifo_rreq(fifo_rreq), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
        .host_wreq(host_wreq), .host_waddr(host_waddr), .host_wdata(host_wdata),
        .ram_wreq(ram_wreq), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .busy(busy), .done(done), .aborted(aborted), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_update();
        fifo_rempty = (q.size() == 0);
        fifo_rdata  = fifo_rempty ? 16'h0000 : q[0];
    endtask

    // Check one cycle's outputs mid-cycle, then advance; the FIFO model pops on rreq.
    task automatic run_cycle(input string tag, input bit rq, input bit wr,
                             input logic [7:0] a, input logic [15:0] d,
                             input bit bs, input bit dn);
        @(negedge clk);
        chk({tag, ".rreq"}, {31'd0, fifo_rreq}, {31'd0, rq});
        chk({tag, ".wreq"}, {31'd0, ram_wreq}, {31'd0, wr});
        if (wr) begin
            chk({tag, ".waddr"}, {24'd0, ram_waddr}, {24'd0, a});
            chk({tag, ".wdata"}, {16'd0, ram_wdata}, {16'd0, d});
        end
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, bs});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, dn});
        pop = fifo_rreq;
        @(posedge clk);
        #1;
        if (pop && q.size() > 0) void'(q.pop_front());
        fifo_update();
        start     = 1'b0;
        abort     = 1'b0;
        host_wreq = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = 8'h00; length = 9'd0;
        host_wreq = 1'b0; host_waddr = 8'h00; host_wdata = 16'h0000;
        fifo_update();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.wreq",  {31'd0, ram_wreq}, 32'd0);
        chk("rst.waddr", {24'd0, ram_waddr}, 32'd0);
        chk("rst.wdata", {16'd0, ram_wdata}, 32'd0);
        chk("rst.busy",  {31'd0, busy}, 32'd0);
        chk("rst.done",  {31'd0, done}, 32'd0);
        chk("rst.abrt",  {31'd0, aborted}, 32'd0);
        chk("rst.cnt",   {23'd0, xfer_cnt}, 32'd0);
        chk("rst.rreq",  {31'd0, fifo_rreq}, 32'd0);
        rst = 1'b0;

        // Basic 4-word burst
        q = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
        fifo_update();
        base_addr = 8'h10; length = 9'd4; start = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            run_cycle($sformatf("t1c%0d", c), c >= 1 && c <= 4, c >= 2 && c <= 5,
                      8'(8'h0E + c), 16'(16'h9FFE + c), c >= 1 && c <= 4, c == 5);
        end
        chk("t1.cnt",  {23'd0, xfer_cnt}, 32'd4);
        chk("t1.abrt", {31'd0, aborted}, 32'd0);
        chk("t1.hold", {24'd0, ram_waddr}, 32'h13);

        // Address wrap
        q = '{16'hB000, 16'hB001, 16'hB002, 16'hB003};
        fifo_update();
        base_addr = 8'hFE; length = 9'd4; start = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            run_cycle($sformatf("t2c%0d", c), c >= 1 && c <= 4, c >= 2 && c <= 5,
                      t2a[c >= 2 ? c - 2 : 0], 16'(16'hAFFE + c),
                      c >= 1 && c <= 4, c == 5);
        end

        // Host write collides with a pop
        q = '{16'hC000, 16'hC001, 16'hC002};
        fifo_update();
        base_addr = 8'h20; length = 9'd3; start = 1'b1;
        run_cycle("t3c0", 0, 0, 8'h00, 16'h0000, 0, 0);
        run_cycle("t3c1", 1, 0, 8'h00, 16'h0000, 1, 0);
        host_wreq = 1'b1; host_waddr = 8'h80; host_wdata = 16'h5555;
        run_cycle("t3c2", 0, 1, 8'h20, 16'hC000, 1, 0);
        run_cycle("t3c3", 1, 1, 8'h80, 16'h5555, 1, 0);
        run_cycle("t3c4", 1, 1, 8'h21, 16'hC001, 1, 0);
        run_cycle("t3c5", 0, 1, 8'h22, 16'hC002, 0, 1);
        chk("t3.cnt", {23'd0, xfer_cnt}, 32'd3);

        // Starved FIFO: words arrive in cycles 5 and 10
        base_addr = 8'h40; length = 9'd2; start = 1'b1;
        run_cycle("t4c0", 0, 0, 8'h00, 16'h0000, 0, 0);
        for (int c = 1; c <= 11; c++) begin
            if (c == 5) q.push_back(16'hD000);
            if (c == 10) q.push_back(16'hD001);
            fifo_update();
            run_cycle($sformatf("t4c%0d", c), c == 5 || c == 10, c == 6 || c == 11,
                      c == 6 ? 8'h40 : 8'h41, c == 6 ? 16'hD000 : 16'hD001,
                      c <= 10, c == 11);
        end

        // Abort after three pops, then restart clears aborted
        q = '{16'hE000, 16'hE001, 16'hE002, 16'hE003,
              16'hE004, 16'hE005, 16'hE006, 16'hE007};
        fifo_update();
        base_addr = 8'h50; length = 9'd8; start = 1'b1;
        run_cycle("t5c0", 0, 0, 8'h00, 16'h0000, 0, 0);
        run_cycle("t5c1", 1, 0, 8'h00, 16'h0000, 1, 0);
        run_cycle("t5c2", 1, 1, 8'h50, 16'hE000, 1, 0);
        run_cycle("t5c3", 1, 1, 8'h51, 16'hE001, 1, 0);
        abort = 1'b1;
        run_cycle("t5c4", 0, 1, 8'h52, 16'hE002, 1, 0);
        run_cycle("t5c5", 0, 0, 8'h00, 16'h0000, 0, 1);
        chk("t5.abrt", {31'd0, aborted}, 32'd1);
        chk("t5.cnt",  {23'd0, xfer_cnt}, 32'd3);
        base_addr = 8'h60; length = 9'd1; start = 1'b1;
        run_cycle("t5c6", 0, 0, 8'h00, 16'h0000, 0, 0);
        chk("t5.clr", {31'd0, aborted}, 32'd0);
        run_cycle("t5c7", 1, 0, 8'h00, 16'h0000, 1, 0);
        run_cycle("t5c8", 0, 1, 8'h60, 16'hE003, 0, 1);
        chk("t5.cnt1", {23'd0, xfer_cnt}, 32'd1);

        // Reset in the middle of a transfer
        base_addr = 8'h70; length = 9'd5; start = 1'b1;
        run_cycle("t6c0", 0, 0, 8'h00, 16'h0000, 0, 0);
        run_cycle("t6c1", 1, 0, 8'h00, 16'h0000, 1, 0);
        run_cycle("t6c2", 1, 1, 8'h70, 16'hE004, 1, 0);
        chk("t6.pre", {31'd0, ram_wreq}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6.wreq",  {31'd0, ram_wreq}, 32'd0);
        chk("t6.waddr", {24'd0, ram_waddr}, 32'd0);
        chk("t6.wdata", {16'd0, ram_wdata}, 32'd0);
        chk("t6.busy",  {31'd0, busy}, 32'd0);
        chk("t6.rreq",  {31'd0, fifo_rreq}, 32'd0);
        chk("t6.cnt",   {23'd0, xfer_cnt}, 32'd0);
        @(posedge clk);
        #1;
        chk("t6.done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t6.qsz", q.size(), 32'd2);
        length = 9'd0; start = 1'b1;
        run_cycle("t7c0", 0, 0, 8'h00, 16'h0000, 0, 0);
        run_cycle("t7c1", 0, 0, 8'h00, 16'h0000, 0, 1);
        run_cycle("t7c2", 0, 0, 8'h00, 16'h0000, 0, 0);
        chk("t7.qsz", q.size(), 32'd2);
        chk("t7.cnt", {23'd0, xfer_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo2ram_dma.md
# fifo2ram_dma

Transfer controller that drains the SPI-fed write FIFO into the block RAM without MCU involvement per word. It sits between the SPI register interface and the single-write-port RAM: it owns the FIFO read side and arbitrates the RAM write port between host (SPI) writes and its own burst writes. Host writes always win.

## Interface
- WIDTH_DATA, 16, FIFO/RAM data width
- WIDTH_ADDR, 8, RAM address width; length width is WIDTH_ADDR+1
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a transfer when idle
- abort  in  1  level/pulse; terminates an active transfer
- base_addr  in  WIDTH_ADDR  first RAM address, sampled on accepted start
- length  in  WIDTH_ADDR+1  word count 0..256, sampled on accepted start
- fifo_rreq  out  1  FIFO pop, combinational
- fifo_rdata  in  WIDTH_DATA  show-ahead FIFO head, valid while !fifo_rempty
- fifo_rempty  in  1  FIFO empty
- host_wreq  in  1  host RAM write request, one cycle
- host_waddr  in  WIDTH_ADDR  host write address
- host_wdata  in  WIDTH_DATA  host write data
- ram_wreq  out  1  RAM write strobe, registered
- ram_waddr  out  WIDTH_ADDR  RAM write address, registered
- ram_wdata  out  WIDTH_DATA  RAM write data, registered
- busy  out  1  high while in XFER
- done  out  1  one-cycle pulse at transfer end
- aborted  out  1  set with done when terminated by abort; cleared on next accepted start
- xfer_cnt  out  WIDTH_ADDR+1  words popped in current/last transfer

## Operation
- States: IDLE, XFER, DONE.
- IDLE: start=1 -> latch ptr<=base_addr, len<=length, xfer_cnt<=0, aborted<=0; go XFER, or DONE if length==0.
- XFER: pop condition P = !fifo_rempty && !host_wreq && !abort && (xfer_cnt != len).
  - P: fifo_rreq=1; register ram_wreq=1, ram_waddr=ptr, ram_wdata=fifo_rdata; ptr<=ptr+1 mod 2^WIDTH_ADDR (255 wraps to 0); xfer_cnt+1.
  - Last pop (xfer_cnt+1==len) -> DONE.
  - abort=1 -> DONE, aborted<=1, no pop that cycle.
  - FIFO empty: wait in XFER indefinitely, no timeout.
- DONE: done=1 for exactly one cycle; -> IDLE.
- start outside IDLE ignored; abort outside XFER ignored.
- Host path, any state: host_wreq=1 -> register ram_wreq=1, ram_waddr=host_waddr, ram_wdata=host_wdata. A DMA pop is suppressed that cycle and retried the next. At most one RAM write per cycle.
- Neither source writing: ram_wreq=0; ram_waddr/ram_wdata hold last value.
- Same address written by host and DMA in different cycles: last write wins; no coherency checks.

## Timing
- Reset (async assert, sync release): state=IDLE; ram_wreq, ram_waddr, ram_wdata, busy, done, aborted, xfer_cnt = 0; internal ptr/len = 0. fifo_rreq=0 while rst high.
- Reset mid-transfer: immediate abort without done pulse; FIFO contents untouched beyond pops already issued.
- start at cycle 0 -> busy=1 from cycle 1; first pop possible in cycle 1.
- Pop in cycle k -> RAM write strobe in cycle k+1. Latency 1.
- Throughput: 1 word/cycle with FIFO non-empty and no host writes.
- Last pop in cycle k -> busy=0 and done=1 in cycle k+1, coinciding with the last ram_wreq; IDLE in k+2. The next start is accepted in k+2.
- length==0: start at cycle 0 -> done=1 in cycle 1, no pops, busy never high.
- abort in cycle k, with no pop in k -> done=1, aborted=1 in k+1.

## Test plan
- FIFO preloaded 0xA000..0xA003, base_addr=0x10, length=4 -> pops in cycles 1-4; RAM writes 0x10..0x13 with 0xA000..0xA003 in cycles 2-5; done in cycle 5; xfer_cnt=4; aborted=0.
- base_addr=0xFE, length=4 -> writes go to 0xFE, 0xFF, 0x00, 0x01.
- length=3 transfer, host_wreq to addr 0x80 data 0x5555 in cycle 2 -> cycle 3 RAM write is host 0x80/0x5555; DMA pop delayed one cycle; done in cycle 5; all three DMA words still written.
- FIFO empty at start, length=2; push one word at cycle 5 and one at cycle 10 -> pops only when non-empty; done one cycle after the second pop; busy stays high throughout.
- length=8, abort in cycle 4 after 3 pops -> no pop in cycle 4; done=1 and aborted=1 in cycle 5; xfer_cnt=3; a further start in cycle 6 clears aborted.
- rst asserted mid-transfer -> all outputs 0 immediately and no done pulse; length=0 start afterwards -> done in cycle 1 with no FIFO or RAM activity.
